imem_fetch_ctrl: RTL and testbench
==================================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 Parameter HALT_ON_ZERO, default 1: a fetched word of 32'h00000000 halts fetch.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 EN  input  1  fetch enable; low pauses issuing new fetches.
REQ-006 IMEM_A  output  8  byte address to the instruction ROM; equals the PC register.
REQ-007 IMEM_RD  input  32  ROM read data, combinational from IMEM_A in the same cycle.
REQ-008 BR_TAKEN  input  1  single-cycle redirect request.
REQ-009 BR_TARGET  input  8  redirect byte address.
REQ-010 INSTR  output  32  registered instruction word.
REQ-011 INSTR_PC  output  8  address INSTR was fetched from.
REQ-012 INSTR_VALID  output  1  INSTR/INSTR_PC hold a valid instruction.
REQ-013 INSTR_READY  input  1  consumer accepts; a transfer occurs when INSTR_VALID and INSTR_READY are both 1 on a rising edge.
REQ-014 HALTED  output  1  high while in HALT state.

Function
REQ-015 States SHALL be: IDLE, FETCH, HOLD, HALT.
REQ-016 IDLE -> FETCH when EN=1; FETCH/HOLD -> IDLE when EN=0 and the output register is empty or being transferred.
REQ-017 In FETCH, a capture SHALL occur when the output register is empty or being transferred: INSTR<=IMEM_RD, INSTR_PC<=PC, INSTR_VALID<=1, PC<=PC+4.
REQ-018 PC arithmetic SHALL be 8-bit modulo 256: 8'hFC+4 wraps to 8'h00. Bits [1:0] of PC SHALL always be 0.
REQ-019 FETCH -> HOLD when INSTR_VALID=1 and INSTR_READY=0. In HOLD, PC, INSTR, INSTR_PC and INSTR_VALID SHALL be frozen.
REQ-020 HOLD -> FETCH on a transfer; the same edge SHALL capture the next word.
REQ-021 Steady-state throughput SHALL be 1 instruction per cycle with INSTR_READY held high. Latency from PC to INSTR_VALID SHALL be 1 cycle.
REQ-022 BR_TAKEN=1 in any state except IDLE SHALL take priority over capture and HOLD:
  - PC<=BR_TARGET with bits [1:0] forced to 0.
  - INSTR_VALID<=0 (flush).
  - Next state FETCH.
REQ-023 BR_TAKEN in IDLE SHALL load PC only; state remains IDLE.
REQ-024 When HALT_ON_ZERO=1 and a capture sees IMEM_RD=32'h00000000:
  - No capture occurs; INSTR_VALID<=0 once any pending word has transferred.
  - PC is held.
  - State <= HALT.
REQ-025 HALT SHALL be exited only by BR_TAKEN (to FETCH) or RST. EN has no effect in HALT.
REQ-026 When HALT_ON_ZERO=0, a zero word SHALL be delivered like any other instruction.
REQ-027 INSTR and INSTR_PC SHALL be stable whenever INSTR_VALID=1 and no transfer or flush occurs.

Reset
REQ-028 RST=1 SHALL immediately, without a clock:
  - PC=RESET_PC; IMEM_A=RESET_PC.
  - INSTR=32'h00000000; INSTR_PC=8'h00.
  - INSTR_VALID=0; HALTED=0; state=IDLE.
REQ-029 Reset asserted mid-HOLD or mid-HALT SHALL discard the pending instruction with no transfer.
REQ-030 After RST deasserts with EN=1, the first capture SHALL happen on the second rising edge: IDLE->FETCH, then capture.

Structure
REQ-031 A shared package SHALL hold:
  - the state enum;
  - PC_STEP=4;
  - HALT_WORD=32'h00000000;
  - the address and data width constants (8, 32).
REQ-032 One sub-module, fetch_pc_counter, SHALL contain the PC register with load, increment-by-4 and hold controls. All other logic SHALL stay in imem_fetch_ctrl.
REQ-033 The ROM SHALL remain external; this block SHALL NOT instantiate it.

Verification
REQ-034 Straight-line run:
  - Stimulus: ROM with 0x0AB00093@00, 0x00100523@04, 0x00A00103@08, 0x002005A3@0C, 0x00B00183@10, 0x00300623@14, 0x00C00203@18; READY=1; EN=1.
  - Response: 7 transfers in 7 consecutive cycles with INSTR_PC 00..18; then HALTED=1 with PC=8'h1C.
REQ-035 Backpressure:
  - Stimulus: READY=0 for 3 cycles while INSTR=0x00100523, INSTR_PC=04.
  - Response: outputs frozen, IMEM_A=08; after READY=1, the next word transferred is 0x00A00103.
REQ-036 Redirect:
  - Stimulus: BR_TAKEN=1 with BR_TARGET=8'h11 during HOLD.
  - Response: next cycle INSTR_VALID=0 and IMEM_A=8'h10; the following transfer is 0x00B00183 with INSTR_PC=10.
REQ-037 Wrap-around:
  - Stimulus: RESET_PC=8'hFC, HALT_ON_ZERO=0, non-zero word at FC.
  - Response: transfer with INSTR_PC=FC, then IMEM_A=8'h00.
REQ-038 Async reset:
  - Stimulus: RST pulsed between clock edges while in HOLD.
  - Response: INSTR_VALID=0 and IMEM_A=RESET_PC immediately; no transfer.
REQ-039 Halt exit:
  - Stimulus: BR_TAKEN=1 with BR_TARGET=8'h00 while in HALT.
  - Response: HALTED=0 next cycle, followed by a transfer of 0x0AB00093.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: bus widths,
// PC step, the halt marker word, the controller state encoding and an
// address alignment helper.
package imem_fetch_ctrl_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    // Byte increment between consecutive 32-bit instruction words.
    localparam logic [ADDR_W-1:0] PC_STEP = 8'd4;

    // A fetched word equal to this value stops fetching when halting is enabled.
    localparam logic [DATA_W-1:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    // Force a byte address onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_pc_counter.sv
// Program counter register for the fetch controller. Supports a word
// aligned load, a wrap-around increment by one word, and hold (neither).
// Load wins over increment.
module fetch_pc_counter
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_reg;

    // PC register: the low two bits stay zero for every source of a new value,
    // and the increment wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= align_addr(RESET_PC);
        end else if (load) begin
            pc_reg <= align_addr(load_value);
        end else if (inc) begin
            pc_reg <= pc_reg + PC_STEP;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller. Drives the external ROM address from the
// PC, captures the returned word into a single output register with a
// valid/ready handshake, handles redirects (flush + PC load) and stops
// fetching when an all-zero word is seen (when enabled).
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC     = 8'h00,
    parameter bit                HALT_ON_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] imem_a,
    input  logic [DATA_W-1:0] imem_rd,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              halted
);

    fetch_state_t      state_reg;
    fetch_state_t      state_next;

    logic [ADDR_W-1:0] pc;
    logic              pc_load;
    logic              pc_inc;

    logic [DATA_W-1:0] instr_reg;
    logic [ADDR_W-1:0] instr_pc_reg;
    logic              instr_valid_reg;

    logic              capture;
    logic              valid_clear;
    logic              stalled;
    logic              halt_seen;

    fetch_pc_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .load       (pc_load),
        .load_value (br_target),
        .inc        (pc_inc),
        .pc         (pc)
    );

    // The output register is occupied and the consumer refuses it this cycle.
    assign stalled   = instr_valid_reg & ~instr_ready;
    assign halt_seen = HALT_ON_ZERO && (imem_rd == HALT_WORD);

    // Next-state and datapath control. FETCH and HOLD share one decision
    // tree: HOLD is simply the label for a stalled FETCH, and leaving it on
    // a transfer captures the next word on the same edge.
    always_comb begin
        state_next  = state_reg;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        capture     = 1'b0;
        valid_clear = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Output register is always empty here; a redirect only moves the PC.
                if (br_taken) begin
                    pc_load = 1'b1;
                end else if (en) begin
                    state_next = ST_FETCH;
                end
            end

            ST_FETCH, ST_HOLD: begin
                if (br_taken) begin
                    pc_load     = 1'b1;
                    valid_clear = 1'b1;
                    state_next  = ST_FETCH;
                end else if (stalled) begin
                    state_next = ST_HOLD;
                end else if (!en) begin
                    // Any pending word is transferring on this edge.
                    valid_clear = 1'b1;
                    state_next  = ST_IDLE;
                end else if (halt_seen) begin
                    valid_clear = 1'b1;
                    state_next  = ST_HALT;
                end else begin
                    capture    = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = ST_FETCH;
                end
            end

            ST_HALT: begin
                // Only a redirect restarts fetching; EN is ignored.
                if (br_taken) begin
                    pc_load     = 1'b1;
                    valid_clear = 1'b1;
                    state_next  = ST_FETCH;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Output instruction register; contents change only on capture so they
    // stay stable while a word waits for the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_reg       <= '0;
            instr_pc_reg    <= '0;
            instr_valid_reg <= 1'b0;
        end else if (capture) begin
            instr_reg       <= imem_rd;
            instr_pc_reg    <= pc;
            instr_valid_reg <= 1'b1;
        end else if (valid_clear) begin
            instr_valid_reg <= 1'b0;
        end
    end

    assign imem_a      = pc;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = instr_valid_reg;
    assign halted      = (state_reg == ST_HALT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a vector table covering straight-line
// fetch, halt, halt exit, backpressure, redirect and EN pause, followed by
// hand-written asynchronous reset and PC wrap-around sequences.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: RESET_PC=00, halting enabled.
    logic        rst, en, br_taken, instr_ready, instr_valid, halted;
    logic [7:0]  br_target, imem_a, instr_pc;
    logic [31:0] imem_rd, instr;

    // Wrap instance: RESET_PC=FC, halting disabled.
    logic        rst2, en2, br_taken2, instr_ready2, instr_valid2, halted2;
    logic [7:0]  br_target2, imem_a2, instr_pc2;
    logic [31:0] imem_rd2, instr2;

    int checks = 0;
    int errors = 0;
    int xfer_count = 0;

    function automatic logic [31:0] rom1(input logic [7:0] a);
        case (a)
            8'h00:   return 32'h0AB00093;
            8'h04:   return 32'h00100523;
            8'h08:   return 32'h00A00103;
            8'h0C:   return 32'h002005A3;
            8'h10:   return 32'h00B00183;
            8'h14:   return 32'h00300623;
            8'h18:   return 32'h00C00203;
            default: return 32'h00000000;
        endcase
    endfunction

    function automatic logic [31:0] rom2(input logic [7:0] a);
        if (a == 8'hFC) return 32'hDEADBEEF;
        return {24'h123456, a};
    endfunction

    assign imem_rd  = rom1(imem_a);
    assign imem_rd2 = rom2(imem_a2);

    imem_fetch_ctrl #(.RESET_PC(8'h00), .HALT_ON_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .imem_a(imem_a), .imem_rd(imem_rd),
        .br_taken(br_taken), .br_target(br_target), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .halted(halted)
    );

    imem_fetch_ctrl #(.RESET_PC(8'hFC), .HALT_ON_ZERO(1'b0)) dut_wrap (
        .clk(clk), .rst(rst2), .en(en2), .imem_a(imem_a2), .imem_rd(imem_rd2),
        .br_taken(br_taken2), .br_target(br_target2), .instr(instr2),
        .instr_pc(instr_pc2), .instr_valid(instr_valid2),
        .instr_ready(instr_ready2), .halted(halted2)
    );

    // Count handshakes on the main instance.
    always @(posedge clk) begin
        if (instr_valid && instr_ready) xfer_count++;
    end

    typedef struct {
        logic        en;
        logic        ready;
        logic        br;
        logic [7:0]  tgt;
        logic        ev;
        logic [31:0] ei;
        logic [7:0]  epc;
        logic [7:0]  ea;
        logic        eh;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic r, input logic b, input logic [7:0] t,
                       input logic ev, input logic [31:0] ei, input logic [7:0] epc,
                       input logic [7:0] ea, input logic eh);
        vec_t v;
        v.en = e; v.ready = r; v.br = b; v.tgt = t;
        v.ev = ev; v.ei = ei; v.epc = epc; v.ea = ea; v.eh = eh;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int xc;
        rst = 1'b1; en = 1'b0; br_taken = 1'b0; br_target = 8'h00; instr_ready = 1'b1;
        rst2 = 1'b1; en2 = 1'b0; br_taken2 = 1'b0; br_target2 = 8'h00; instr_ready2 = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_imem_a", imem_a, 8'h00);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 8'h00);
        chk("rst_halted", halted, 1'b0);

        //   en   rdy  br   tgt    valid instr          ipc    imem_a halted
        // straight-line run to the halt word at 1C
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,        8'h00, 8'h00, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h0AB00093, 8'h00, 8'h04, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h00100523, 8'h04, 8'h08, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h00A00103, 8'h08, 8'h0C, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h002005A3, 8'h0C, 8'h10, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h00B00183, 8'h10, 8'h14, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h00300623, 8'h14, 8'h18, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h00C00203, 8'h18, 8'h1C, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,        8'h00, 8'h1C, 1'b1);
        // EN low has no effect in HALT
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,        8'h00, 8'h1C, 1'b1);
        // halt exit by redirect to 00
        add(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 32'h0,        8'h00, 8'h00, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h0AB00093, 8'h00, 8'h04, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h00100523, 8'h04, 8'h08, 1'b0);
        // backpressure for three cycles
        add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h00100523, 8'h04, 8'h08, 1'b0);
        add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h00100523, 8'h04, 8'h08, 1'b0);
        add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h00100523, 8'h04, 8'h08, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h00A00103, 8'h08, 8'h0C, 1'b0);
        // redirect to 11 while in HOLD
        add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'h00A00103, 8'h08, 8'h0C, 1'b0);
        add(1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 32'h0,        8'h00, 8'h10, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h00B00183, 8'h10, 8'h14, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h00300623, 8'h14, 8'h18, 1'b0);
        // EN pause into IDLE, redirect in IDLE moves PC only, then resume
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,        8'h00, 8'h18, 1'b0);
        add(1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 32'h0,        8'h00, 8'h04, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0,        8'h00, 8'h04, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 32'h00100523, 8'h04, 8'h08, 1'b0);

        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en; instr_ready = vecs[i].ready;
            br_taken = vecs[i].br; br_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            $display("vec %0d en=%b rdy=%b br=%b tgt=%h -> valid=%b instr=%h ipc=%h a=%h halted=%b",
                     i, en, instr_ready, br_taken, br_target, instr_valid, instr, instr_pc, imem_a, halted);
            chk($sformatf("vec%0d_valid", i), instr_valid, vecs[i].ev);
            chk($sformatf("vec%0d_imem_a", i), imem_a, vecs[i].ea);
            chk($sformatf("vec%0d_halted", i), halted, vecs[i].eh);
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_instr", i), instr, vecs[i].ei);
                chk($sformatf("vec%0d_instr_pc", i), instr_pc, vecs[i].epc);
            end
            if (i == 8) chk("straight_xfers", xfer_count, 7);
        end
        br_taken = 1'b0;

        // Asynchronous reset while holding a word.
        instr_ready = 1'b0;
        @(posedge clk);
        #1;
        $display("hold before reset: valid=%b ipc=%h a=%h", instr_valid, instr_pc, imem_a);
        chk("hold_valid", instr_valid, 1'b1);
        chk("hold_instr_pc", instr_pc, 8'h04);
        chk("hold_imem_a", imem_a, 8'h08);
        #2 rst = 1'b1;
        #1;
        $display("async reset mid-cycle: valid=%b a=%h", instr_valid, imem_a);
        chk("arst_valid", instr_valid, 1'b0);
        chk("arst_imem_a", imem_a, 8'h00);
        chk("arst_instr", instr, 32'h0);
        chk("arst_halted", halted, 1'b0);
        xc = xfer_count;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_held_valid", instr_valid, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_edge1_valid", instr_valid, 1'b0);
        @(posedge clk);
        #1;
        $display("post reset capture: valid=%b instr=%h ipc=%h", instr_valid, instr, instr_pc);
        chk("post_rst_edge2_valid", instr_valid, 1'b1);
        chk("post_rst_instr", instr, 32'h0AB00093);
        chk("post_rst_instr_pc", instr_pc, 8'h00);
        chk("arst_no_xfer", xfer_count, xc);

        // PC wrap-around on the second instance.
        rst2 = 1'b0; en2 = 1'b1; instr_ready2 = 1'b1;
        @(posedge clk);
        #1;
        chk("wrap_e1_valid", instr_valid2, 1'b0);
        chk("wrap_e1_imem_a", imem_a2, 8'hFC);
        @(posedge clk);
        #1;
        $display("wrap capture: valid=%b instr=%h ipc=%h a=%h", instr_valid2, instr2, instr_pc2, imem_a2);
        chk("wrap_valid", instr_valid2, 1'b1);
        chk("wrap_instr", instr2, 32'hDEADBEEF);
        chk("wrap_instr_pc", instr_pc2, 8'hFC);
        chk("wrap_imem_a", imem_a2, 8'h00);
        @(posedge clk);
        #1;
        $display("wrap next: valid=%b instr=%h ipc=%h a=%h", instr_valid2, instr2, instr_pc2, imem_a2);
        chk("wrap_next_instr", instr2, 32'h12345600);
        chk("wrap_next_instr_pc", instr_pc2, 8'h00);
        chk("wrap_next_imem_a", imem_a2, 8'h04);
        chk("wrap_halted", halted2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
